// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared definitions for the FFT stage sequencer
// Purpose: FSM state encoding, default transform geometry and the
//          ping-pong bank-select convention.
// Ports:   none (package).
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  localparam int DEF_N_POINTS = 16;
  localparam int DEF_LOG2N    = 4;
  localparam int DEF_STAGE_W  = 3;

  // o_bank names the read bank; the datapath writes the opposite bank.
  // Every transform reads its input from this bank in stage 0.
  localparam logic BANK_FIRST = 1'b0;

endpackage

// File: rtl/fft_stage_seq_if.sv
// rtl/fft_stage_seq_if.sv - control/datapath signal bundle of the stage sequencer
// Purpose: groups go/abort/dv inputs and the sequencer outputs.
// Ports:   master drives i_go, i_abort, i_dv and observes the outputs;
//          slave (the sequencer) drives o_start, o_stage, o_bank, o_we,
//          o_busy, o_done, o_err.
interface fft_stage_seq_if
  import fft_pkg::*;
#(
  parameter int STAGE_W = DEF_STAGE_W
) ();

  logic               i_go;
  logic               i_abort;
  logic               i_dv;
  logic               o_start;
  logic [STAGE_W-1:0] o_stage;
  logic               o_bank;
  logic               o_we;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    output i_go, i_abort, i_dv,
    input  o_start, o_stage, o_bank, o_we, o_busy, o_done, o_err
  );

  modport slave (
    input  i_go, i_abort, i_dv,
    output o_start, o_stage, o_bank, o_we, o_busy, o_done, o_err
  );

endinterface

// File: rtl/fft_seq_wdog.sv
// rtl/fft_seq_wdog.sv - watchdog counter for stalled RUN phases
// Purpose: counts enabled cycles since the last clear and flags the cycle
//          that completes WDOG_CYCLES consecutive enabled, uncleared cycles.
// Ports:   clk, rst_n (async active-low); i_clr zeroes the count;
//          i_en counts; o_term terminal flag (combinational).
module fft_seq_wdog #(
  parameter int WDOG_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the idle cycles already elapsed, so the current cycle is
  // the WDOG_CYCLES-th one when cnt_q reaches WDOG_CYCLES-1.
  assign o_term = i_en & ~i_clr & (cnt_q == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && !o_term) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fft_stage_seq.sv
// rtl/fft_stage_seq.sv - radix-2 FFT stage sequencer (launch/run/drain per stage)
// Purpose: runs LOG2N stages, one o_start per stage, counts N_POINTS/2
//          butterfly strobes, waits PIPE_LAT flush cycles, then advances the
//          stage and flips the ping-pong bank. Optional watchdog under
//          FFT_SEQ_WDOG_EN.
// Ports:   clk, rst_n (async active-low); bus (fft_stage_seq_if.slave):
//          i_go, i_abort, i_dv in; o_start, o_stage, o_bank, o_we (comb),
//          o_busy, o_done, o_err out.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int N_POINTS    = DEF_N_POINTS,
  parameter int LOG2N       = DEF_LOG2N,
  parameter int STAGE_W     = DEF_STAGE_W,
  parameter int PIPE_LAT    = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_stage_seq_if.slave   bus
);

  localparam int BW = $clog2(N_POINTS / 2);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [BW-1:0]      BF_LAST    = BW'(N_POINTS / 2 - 1);
  localparam logic [DW-1:0]      DR_LOAD    = DW'(PIPE_LAT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  seq_state_e         state_q, state_d;
  logic [BW-1:0]      bf_cnt_q;
  logic [DW-1:0]      dr_cnt_q;
  logic [STAGE_W-1:0] stage_q;
  logic               bank_q;
  logic               start_q, busy_q, done_q;
  logic               go_take, stage_adv, bf_inc, dr_load;
  logic               wdog_term;

`ifdef FFT_SEQ_WDOG_EN
  logic err_q;

  // Held clear outside RUN so it always starts from zero on RUN entry.
  fft_seq_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  ((state_q != ST_RUN) | bus.i_dv),
    .i_en   (state_q == ST_RUN),
    .o_term (wdog_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (go_take) begin
      err_q <= 1'b0;
    end else if (wdog_term && !bus.i_abort) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`else
  assign wdog_term = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    go_take   = 1'b0;
    stage_adv = 1'b0;
    bf_inc    = 1'b0;
    dr_load   = 1'b0;
    if (state_q != ST_IDLE && bus.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_go) begin
            state_d = ST_LAUNCH;
            go_take = 1'b1;
          end
        end
        ST_LAUNCH: state_d = ST_RUN;
        ST_RUN: begin
          if (wdog_term) begin
            state_d = ST_IDLE;
          end else if (bus.i_dv) begin
            // The terminal strobe leaves RUN, so the count never wraps.
            if (bf_cnt_q == BF_LAST) begin
              state_d = ST_DRAIN;
              dr_load = 1'b1;
            end else begin
              bf_inc = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (dr_cnt_q == '0) begin
            if (stage_q == STAGE_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d   = ST_LAUNCH;
              stage_adv = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bf_cnt_q <= '0;
      dr_cnt_q <= '0;
      stage_q  <= '0;
      bank_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Pulse/status outputs are decoded from the next state so they are
      // registered and line up exactly with the state they describe.
      start_q <= (state_d == ST_LAUNCH);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);

      if (go_take || state_q == ST_LAUNCH) begin
        bf_cnt_q <= '0;
      end else if (bf_inc) begin
        bf_cnt_q <= bf_cnt_q + BW'(1);
      end

      if (dr_load) begin
        dr_cnt_q <= DR_LOAD;
      end else if (state_q == ST_DRAIN && dr_cnt_q != '0) begin
        dr_cnt_q <= dr_cnt_q - DW'(1);
      end

      if (go_take) begin
        stage_q <= '0;
        bank_q  <= BANK_FIRST;
      end else if (stage_adv) begin
        stage_q <= stage_q + STAGE_W'(1);
        bank_q  <= ~bank_q;
      end
    end
  end

  assign bus.o_start = start_q;
  assign bus.o_stage = stage_q;
  assign bus.o_bank  = bank_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_we    = (state_q == ST_RUN) & bus.i_dv;

endmodule

// File: doc/fft_stage_seq.md
# fft_stage_seq

Sequencer for the in-place radix-2 FFT stage datapath: it runs one full transform by issuing one start pulse per stage to the coefficient mapper / butterfly stage, counting its data-valid strobes, flushing the pipeline and advancing the stage index until all log2(N) stages are done. It sits between the top-level control (go/done) and the `c_mapper`/butterfly datapath. It also owns the ping-pong RAM bank select and the RAM write enable.

## Interface
Parameters:
- `N_POINTS`, 16: transform length, power of two, ≥ 4.
- `LOG2N`, 4: log2(N_POINTS), number of stages.
- `STAGE_W`, 3: width of the stage index; must satisfy 2^STAGE_W ≥ LOG2N.
- `PIPE_LAT`, 2: butterfly pipeline flush cycles after the last strobe, ≥ 1.
- `WDOG_CYCLES`, 255: watchdog limit, used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i_go`, in, 1: start a transform; sampled only in IDLE.
- `i_abort`, in, 1: synchronous abort, returns to IDLE.
- `i_dv`, in, 1: datapath data-valid strobe, one per butterfly.
- `o_start`, out, 1: one-cycle start pulse to the datapath.
- `o_stage`, out, STAGE_W: current stage, 0..LOG2N-1.
- `o_bank`, out, 1: read bank; the write bank is `~o_bank`.
- `o_we`, out, 1: RAM write enable; equals `i_dv` while in RUN, else 0.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-cycle pulse on successful completion.
- `o_err`, out, 1: sticky watchdog error.

## Operation
FSM states are IDLE, LAUNCH, RUN, DRAIN, DONE.
- **IDLE:** `i_go`=1 → LAUNCH. The same edge clears `o_stage` to 0, `o_bank` to 0, `o_err` to 0 and the butterfly count.
- **LAUNCH (1 cycle):** `o_start`=1 and the butterfly count is cleared → RUN.
- **RUN:** each cycle with `i_dv`=1 increments the butterfly count. When `i_dv`=1 with count = N_POINTS/2−1 → DRAIN, with the drain counter loaded to PIPE_LAT−1.
- **DRAIN:** the drain counter decrements each cycle. At 0:
  - if `o_stage` = LOG2N−1 → DONE;
  - otherwise `o_stage`+1, `o_bank` toggles, → LAUNCH.
- **DONE (1 cycle):** `o_done`=1 → IDLE. `o_stage` and `o_bank` hold their values.

Boundary rules:
- `i_go` outside IDLE is ignored.
- `i_dv` outside RUN is ignored; it is not counted and `o_we` stays 0.
- `i_abort` in any non-IDLE state → IDLE on the next edge. No `o_done`. Abort has priority over every other transition in the same cycle.
- `i_abort` and `i_go` both high in IDLE: the go is taken.
- The butterfly count is log2(N_POINTS/2) bits and never wraps, because RUN exits on the terminal count.
- Async reset mid-transform: immediate IDLE; all outputs return to their reset values.

## Timing
- Reset values: all outputs 0; state IDLE.
- `i_go` sampled at edge k → `o_start` high during cycle k+1.
- Per stage: 1 (LAUNCH) + RUN cycles + PIPE_LAT cycles.
- With `i_dv` high every RUN cycle, a stage is 1 + N_POINTS/2 + PIPE_LAT cycles. For the defaults that is 11 cycles, and `o_done` is high in cycle k+45.
- `o_we` is combinational from `i_dv` and the state, with zero latency. All other outputs are registered.
- `o_stage` and `o_bank` change only on the DRAIN→LAUNCH edge, so they are stable for the whole stage.

## Configuration
- `FFT_SEQ_WDOG_EN` defined: a watchdog counter runs in RUN.
  - It is cleared on entry to RUN and on every `i_dv`.
  - Reaching WDOG_CYCLES consecutive cycles without `i_dv` → `o_err`=1 and → IDLE, with no `o_done`.
  - `o_err` is cleared only by the next accepted `i_go` or by reset.
- `FFT_SEQ_WDOG_EN` undefined: RUN waits indefinitely, `o_err` is tied to 0, and the counter logic is absent.

## Structure
- The shared package `fft_pkg` holds:
  - the FSM state encoding constants (IDLE=0, LAUNCH=1, RUN=2, DRAIN=3, DONE=4, 3 bits);
  - the default N_POINTS/LOG2N/STAGE_W values;
  - the bank-select convention.
- One sub-module is natural: `fft_seq_wdog`, the watchdog counter with clear/enable inputs and a terminal flag. It is instantiated only under `FFT_SEQ_WDOG_EN`.
- The remaining counters are kept inline in the block.

## Test plan
All scenarios use the default parameters.
- **Reset:** `rst_n` low → all outputs 0. Release, hold `i_go`=0 for 20 cycles → `o_busy` stays 0.
- **Full transform:** `i_go` pulse at edge k, `i_dv` tied high.
  - Four `o_start` pulses, at k+1, k+12, k+23 and k+34.
  - `o_stage` steps 0,1,2,3 and `o_bank` steps 0,1,0,1.
  - `o_we` is high exactly 32 cycles.
  - `o_done` is high only in cycle k+45.
- **Sparse strobes:** `i_dv` every 3rd cycle in RUN → 8 strobes counted per stage, `o_done` after the 32nd strobe + 2 + 1 cycles. Stray `i_dv` in LAUNCH/DRAIN produces no `o_we`.
- **Abort:** `i_abort` in stage 2 RUN → IDLE next cycle, `o_busy`=0, no `o_done`. A following `i_go` restarts at `o_stage`=0, `o_bank`=0.
- **Ignored go:** `i_go` pulsed during stage 1 → no restart; the sequence completes normally.
- **Watchdog (`FFT_SEQ_WDOG_EN`):** `i_dv` stops after 3 strobes in stage 0 → `o_err`=1 after 255 idle cycles, state IDLE, no `o_done`. The next `i_go` clears `o_err`.
